// File: rtl/kpn_queue_arbiter.sv
// kpn_queue_arbiter: round-robin write arbiter and occupancy tracker for a
// single flagless KPN channel queue. Keeps the authoritative token count and
// gates q_wr/q_rd so the queue never sees a write when full or a read when empty.
//
// state      | meaning
// -----------+------------------------------------------
// ST_EMPTY   | occupancy == 0, reads blocked
// ST_PARTIAL | 0 < occupancy < CAP, reads and writes allowed
// ST_FULL    | occupancy == CAP, writes blocked
module kpn_queue_arbiter #(
  parameter int BITS_NUMBER              = 16,
  parameter int FIFO_ELEMENTS            = 5,
  parameter int NUMBER_OF_PRECHARGE_DATA = 0,
  parameter int NUM_PRODUCERS            = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_PRODUCERS-1:0]             prod_req,
  input  logic [NUM_PRODUCERS*BITS_NUMBER-1:0] prod_data,
  output logic [NUM_PRODUCERS-1:0]             prod_ack,
  input  logic                                 cons_rd,
  output logic                                 cons_valid,
  output logic [BITS_NUMBER-1:0]               cons_data,
  output logic                                 q_wr,
  output logic                                 q_rd,
  output logic [BITS_NUMBER-1:0]               q_entry_1,
  input  logic [BITS_NUMBER-1:0]               q_output_1,
  output logic [FIFO_ELEMENTS:0]               occupancy,
  output logic                                 full,
  output logic                                 empty
);

  localparam int CAP = 2 ** FIFO_ELEMENTS;
  localparam int OW  = FIFO_ELEMENTS + 1;
  localparam int PW  = (NUM_PRODUCERS > 1) ? $clog2(NUM_PRODUCERS) : 1;

  localparam logic [OW-1:0] CAP_OCC = OW'(CAP);
  localparam logic [OW-1:0] PRE_OCC = OW'(NUMBER_OF_PRECHARGE_DATA);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  localparam state_t ST_RST = (NUMBER_OF_PRECHARGE_DATA == 0)   ? ST_EMPTY :
                              (NUMBER_OF_PRECHARGE_DATA == CAP) ? ST_FULL  :
                                                                  ST_PARTIAL;

  state_t          state_q, state_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic [PW-1:0]   rr_q, rr_d;

  logic            grant_found;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   cand;
  logic            wr_ok;

  // Controller state registers: FSM state, token count, round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RST;
      occ_q   <= PRE_OCC;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      rr_q    <= rr_d;
    end
  end

  // Round-robin search: first requester at or after rr_q, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_q;
    cand        = rr_q;
    for (int k = 0; k < NUM_PRODUCERS; k++) begin
      cand = PW'((int'(rr_q) + k) % NUM_PRODUCERS);
      if (!grant_found && prod_req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Grant gating, queue strobes and write-data mux. A full queue blocks the
  // write even when a read happens in the same cycle, because the queue would
  // still advance its write pointer.
  always_comb begin
    wr_ok     = (state_q != ST_FULL);
    prod_ack  = '0;
    q_entry_1 = prod_data[BITS_NUMBER-1:0];
    for (int i = 0; i < NUM_PRODUCERS; i++) begin
      if (grant_idx == PW'(i)) begin
        prod_ack[i] = wr_ok & grant_found;
        q_entry_1   = prod_data[i*BITS_NUMBER +: BITS_NUMBER];
      end
    end
    q_wr = wr_ok & grant_found;
    q_rd = cons_rd & (state_q != ST_EMPTY);
  end

  // Next-state: count update, occupancy FSM transitions, pointer advance.
  always_comb begin
    occ_d   = occ_q;
    state_d = state_q;
    rr_d    = rr_q;

    if (q_wr && !q_rd) begin
      occ_d = occ_q + 1'b1;
    end else if (q_rd && !q_wr) begin
      occ_d = occ_q - 1'b1;
    end

    unique case (state_q)
      ST_EMPTY: begin
        if (q_wr) state_d = (CAP_OCC == OW'(1)) ? ST_FULL : ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (q_wr && !q_rd && occ_q == CAP_OCC - 1'b1) state_d = ST_FULL;
        else if (q_rd && !q_wr && occ_q == OW'(1))    state_d = ST_EMPTY;
      end
      ST_FULL: begin
        if (q_rd) state_d = (CAP_OCC == OW'(1)) ? ST_EMPTY : ST_PARTIAL;
      end
      default: state_d = ST_RST;
    endcase

    if (q_wr) begin
      rr_d = (grant_idx == PW'(NUM_PRODUCERS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Status outputs decode the registered state; head data is a pass-through.
  always_comb begin
    full       = (state_q == ST_FULL);
    empty      = (state_q == ST_EMPTY);
    cons_valid = ~empty;
    cons_data  = q_output_1;
    occupancy  = occ_q;
  end

endmodule

// File: tb/tb_kpn_queue_arbiter.sv
// Bench for kpn_queue_arbiter: a behavioural queue sits on the q_* side, and a
// token-list model predicts every output each cycle.
module tb_kpn_queue_arbiter;

  localparam int BITS = 16;
  localparam int FE   = 5;
  localparam int PRE  = 4;
  localparam int NP   = 4;
  localparam int CAP  = 2 ** FE;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NP-1:0]        prod_req;
  logic [NP*BITS-1:0]   prod_data;
  logic [NP-1:0]        prod_ack;
  logic                 cons_rd;
  logic                 cons_valid;
  logic [BITS-1:0]      cons_data;
  logic                 q_wr, q_rd;
  logic [BITS-1:0]      q_entry_1;
  logic [BITS-1:0]      q_output_1;
  logic [FE:0]          occupancy;
  logic                 full, empty;

  int checks   = 0;
  int failures = 0;
  int tok_seed = 0;

  kpn_queue_arbiter #(
    .BITS_NUMBER(BITS), .FIFO_ELEMENTS(FE),
    .NUMBER_OF_PRECHARGE_DATA(PRE), .NUM_PRODUCERS(NP)
  ) dut (
    .clk(clk), .reset(reset), .prod_req(prod_req), .prod_data(prod_data),
    .prod_ack(prod_ack), .cons_rd(cons_rd), .cons_valid(cons_valid),
    .cons_data(cons_data), .q_wr(q_wr), .q_rd(q_rd), .q_entry_1(q_entry_1),
    .q_output_1(q_output_1), .occupancy(occupancy), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  function automatic logic [BITS-1:0] pre_tok(int k);
    return 16'(16'hC000 + k);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural channel queue (re-initialised together with the controller).
  logic [BITS-1:0] qmem [CAP];
  logic [FE-1:0]   qwp, qrp;
  assign q_output_1 = qmem[qrp];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < CAP; k++) qmem[k] <= (k < PRE) ? pre_tok(k) : '0;
      qwp <= FE'(PRE);
      qrp <= '0;
    end else begin
      if (q_wr) begin
        qmem[qwp] <= q_entry_1;
        qwp <= qwp + 1'b1;
      end
      if (q_rd) qrp <= qrp + 1'b1;
    end
  end

  // Model: list of tokens held, count, next producer to favour.
  logic [BITS-1:0] m_tok[$];
  int              m_cnt;
  int              m_rr;
  logic            cap_valid = 1'b0;
  logic            cap_wr, cap_rd;
  logic [BITS-1:0] cap_tok;
  int              cap_rr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_tok.delete();
      for (int k = 0; k < PRE; k++) m_tok.push_back(pre_tok(k));
      m_cnt <= PRE;
      m_rr  <= 0;
    end else if (cap_valid) begin
      if (cap_rd) void'(m_tok.pop_front());
      if (cap_wr) m_tok.push_back(cap_tok);
      m_cnt <= m_cnt + (cap_wr ? 1 : 0) - (cap_rd ? 1 : 0);
      if (cap_wr) m_rr <= cap_rr;
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    int              gi;
    bit              found;
    bit              e_wr, e_rd;
    logic [NP-1:0]   e_ack;
    if (reset) begin
      cap_valid <= 1'b0;
    end else begin
      found = 0;
      gi    = m_rr;
      for (int k = 0; k < NP; k++) begin
        int c;
        c = (m_rr + k) % NP;
        if (!found && prod_req[c]) begin
          found = 1;
          gi    = c;
        end
      end
      e_wr  = found && (m_cnt != CAP);
      e_rd  = cons_rd && (m_cnt != 0);
      e_ack = e_wr ? NP'(1 << gi) : '0;
      chk("prod_ack", 32'(prod_ack), 32'(e_ack));
      chk("q_wr", 32'(q_wr), 32'(e_wr));
      chk("q_rd", 32'(q_rd), 32'(e_rd));
      chk("occupancy", 32'(occupancy), 32'(m_cnt));
      chk("full", 32'(full), 32'(m_cnt == CAP));
      chk("empty", 32'(empty), 32'(m_cnt == 0));
      chk("cons_valid", 32'(cons_valid), 32'(m_cnt != 0));
      if (e_wr) chk("q_entry_1", 32'(q_entry_1), 32'(prod_data[gi*BITS +: BITS]));
      if (m_cnt != 0) chk("cons_data", 32'(cons_data), 32'(m_tok[0]));
      cap_valid <= 1'b1;
      cap_wr    <= e_wr;
      cap_rd    <= e_rd;
      cap_tok   <= prod_data[gi*BITS +: BITS];
      cap_rr    <= (gi + 1) % NP;
    end
  end

  task automatic refresh_data();
    for (int i = 0; i < NP; i++) prod_data[i*BITS +: BITS] = 16'(tok_seed * 8 + i);
  endtask

  // Advance one edge; inputs may be changed right after it returns.
  task automatic step();
    @(posedge clk);
    #1;
    tok_seed++;
    refresh_data();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [BITS-1:0] exp_tok;
    logic [NP-1:0]   exp_ack;
    reset = 1'b1; prod_req = '0; cons_rd = 1'b0;
    refresh_data();
    #12;
    step();
    reset = 1'b0;
    #1;
    chk("rst_occupancy", 32'(occupancy), 32'd4);
    chk("rst_cons_valid", 32'(cons_valid), 32'd1);
    chk("rst_empty", 32'(empty), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ack_idle", 32'(prod_ack), 32'd0);
    prod_req = 4'b1111;
    #1;
    chk("rst_rr_ptr0", 32'(prod_ack), 32'b0001);
    prod_req = '0;

    // Drain precharged tokens, then one ignored read while empty.
    cons_rd = 1'b1;
    repeat (5) step();
    cons_rd = 1'b0;
    #1;
    chk("drained_empty", 32'(empty), 32'd1);
    chk("drained_occ", 32'(occupancy), 32'd0);

    // All producers requesting: strict rotation.
    prod_req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_ack = NP'(1 << (c % 4));
      chk("rr_ack", 32'(prod_ack), 32'(exp_ack));
      chk("rr_entry", 32'(q_entry_1), 32'(tok_seed * 8 + (c % 4)));
      step();
    end
    prod_req = '0;
    #1;
    chk("rr_occ8", 32'(occupancy), 32'd8);

    cons_rd = 1'b1;
    repeat (8) step();
    cons_rd = 1'b0;

    // Fill to capacity from producer 0.
    prod_req = 4'b0001;
    repeat (32) step();
    #1;
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_occ32", 32'(occupancy), 32'd32);
    chk("fill_ack_blocked", 32'(prod_ack), 32'd0);
    chk("fill_qwr_blocked", 32'(q_wr), 32'd0);
    step();
    #1;
    chk("fill_occ_hold", 32'(occupancy), 32'd32);

    // Read + write while full: only the read goes through.
    prod_req = 4'b0010; cons_rd = 1'b1;
    #1;
    chk("full_rw_qrd", 32'(q_rd), 32'd1);
    chk("full_rw_qwr", 32'(q_wr), 32'd0);
    step();
    cons_rd = 1'b0;
    #1;
    chk("full_rw_occ31", 32'(occupancy), 32'd31);
    chk("full_rw_ack_next", 32'(prod_ack), 32'b0010);
    step();
    #1;
    chk("full_rw_occ32", 32'(occupancy), 32'd32);

    prod_req = '0; cons_rd = 1'b1;
    repeat (32) step();
    #1;
    chk("empty_again", 32'(empty), 32'd1);

    // Read + write while empty: only the write goes through.
    prod_req = 4'b0100; cons_rd = 1'b1;
    #1;
    chk("empty_rw_qrd", 32'(q_rd), 32'd0);
    chk("empty_rw_qwr", 32'(q_wr), 32'd1);
    exp_tok = prod_data[2*BITS +: BITS];
    step();
    prod_req = '0; cons_rd = 1'b0;
    #1;
    chk("empty_rw_occ1", 32'(occupancy), 32'd1);
    chk("empty_rw_data", 32'(cons_data), 32'(exp_tok));

    // Partial with both strobes: count holds.
    prod_req = 4'b0001; cons_rd = 1'b1;
    repeat (5) step();
    prod_req = '0; cons_rd = 1'b0;
    #1;
    chk("partial_rw_occ", 32'(occupancy), 32'd1);

    // Climb to 10, then reset asynchronously mid-cycle with requests active.
    prod_req = 4'b1111;
    repeat (9) step();
    #1;
    chk("pre_reset_occ10", 32'(occupancy), 32'd10);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_occ", 32'(occupancy), 32'd4);
    chk("async_rst_ack", 32'(prod_ack), 32'b0001);
    chk("async_rst_valid", 32'(cons_valid), 32'd1);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_ack", 32'(prod_ack), 32'b0001);
    repeat (4) step();
    prod_req = '0;
    #1;
    chk("post_rst_occ8", 32'(occupancy), 32'd8);
    cons_rd = 1'b1;
    repeat (8) step();
    cons_rd = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kpn_queue_arbiter.md
Name: kpn_queue_arbiter

Overview:
- Controller in front of a single KPN channel queue (the 2**FIFO_ELEMENTS-deep register-file FIFO with clk/rd/wr/entry_1/output_1 ports).
- Shares the queue write side among NUM_PRODUCERS process nodes with round-robin arbitration and serves one consumer node.
- The queue exports no flags, so this block keeps the authoritative occupancy count. It gates q_wr/q_rd so the queue never sees an illegal operation (write when full, read when empty, including the simultaneous read+write case).

Parameters:
- BITS_NUMBER, 16, token width.
- FIFO_ELEMENTS, 5, queue address width; capacity CAP = 2**FIFO_ELEMENTS tokens.
- NUMBER_OF_PRECHARGE_DATA, 0, tokens preloaded in the queue at power-up; 0..CAP.
- NUM_PRODUCERS, 4, number of writing processes; 2..8.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- prod_req  input  NUM_PRODUCERS  producer i has a token on its prod_data slice.
- prod_data  input  NUM_PRODUCERS*BITS_NUMBER  producer tokens; slice i = bits [i*BITS_NUMBER +: BITS_NUMBER].
- prod_ack  output  NUM_PRODUCERS  one-hot; token i accepted this cycle (combinational).
- cons_rd  input  1  consumer pops the head token this cycle.
- cons_valid  output  1  head token available (occupancy != 0).
- cons_data  output  BITS_NUMBER  head token; pass-through of q_output_1.
- q_wr  output  1  drives queue wr.
- q_rd  output  1  drives queue rd.
- q_entry_1  output  BITS_NUMBER  drives queue entry_1.
- q_output_1  input  BITS_NUMBER  from queue output_1.
- occupancy  output  FIFO_ELEMENTS+1  tokens currently held.
- full  output  1  occupancy == CAP.
- empty  output  1  occupancy == 0.

Behaviour:
- Reset (async): occupancy <= NUMBER_OF_PRECHARGE_DATA and rr_ptr <= 0. Outputs are then combinational from this state: prod_ack=0 when no requests, cons_valid = (NUMBER_OF_PRECHARGE_DATA != 0), full/empty derived from occupancy.
- The queue has no reset. Asserting reset mid-operation is permitted only when the queue is re-initialised at the same time; otherwise the count desyncs. The bench checks only that the controller's own state returns to reset values.
- Occupancy FSM states are EMPTY (0), PARTIAL (1..CAP-1) and FULL (CAP); full/empty decode the state directly.
- Arbitration (combinational): wr_ok = ~full. Grant goes to the first i with prod_req[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_PRODUCERS. prod_ack = one-hot grant if wr_ok, else all zero.
- q_wr = |prod_ack. q_entry_1 = granted prod_data slice; when q_wr=0, q_entry_1 = slice rr_ptr, value don't-care.
- Pointer update: on a clock edge with q_wr=1 granting i, rr_ptr <= (i+1) mod NUM_PRODUCERS; otherwise it holds. No producer starves: max wait is NUM_PRODUCERS-1 accepted writes.
- Read: q_rd = cons_rd & ~empty. A cons_rd while empty is ignored (no q_rd, no state change). cons_data is valid only while cons_valid=1.
- Occupancy update per edge: +1 if q_wr&~q_rd, -1 if q_rd&~q_wr, unchanged if both or neither.
- Simultaneous read+write when FULL: write is blocked, read proceeds, next occupancy = CAP-1. The queue masks writes when full but still advances its write pointer on rd+wr, so q_wr must stay 0.
- Simultaneous read+write when EMPTY: read is blocked, write proceeds, next occupancy = 1.
- PARTIAL with both: both pulses issued, occupancy unchanged.
- Wrap-around: occupancy never exceeds CAP and never underflows; queue pointer wrap is internal to the queue.
- Latency: accept/pop decisions are same-cycle combinational. The written token is visible on cons_data no earlier than the next cycle.

Test Plan:
- Reset with NUMBER_OF_PRECHARGE_DATA=4, no requests -> occupancy=4, cons_valid=1, empty=0, full=0, rr_ptr=0.
- prod_req=4'b1111 held for 8 cycles from empty, cons_rd=0 -> prod_ack sequence 0001,0010,0100,1000,0001,... ; occupancy 8; q_entry_1 matches the granted slice each cycle.
- Fill to CAP=32 with prod_req=4'b0001 -> full=1 after 32 writes; on 33rd cycle prod_ack=0, q_wr=0, occupancy stays 32.
- At full, prod_req=4'b0010 and cons_rd=1 -> q_rd=1, q_wr=0, occupancy 31; next cycle prod_ack=0010, occupancy 32.
- At empty, prod_req=4'b0100 and cons_rd=1 -> q_rd=0, q_wr=1, occupancy 1; cons_data equals the written token next cycle.
- Occupancy=10, assert reset asynchronously mid-cycle with requests active -> occupancy=NUMBER_OF_PRECHARGE_DATA and rr_ptr=0 immediately; normal arbitration resumes after deassertion.
